// File: rtl/packer_scheduler_if.sv
// Command and packer-side signals of the burst packer scheduler.
// The scheduler takes the slave modport; the command source / packer environment takes master.
interface packer_scheduler_if #(
  parameter int ADDR_W = 16
);
  logic              i_cmd_valid;
  logic              o_cmd_ready;
  logic [9:0]        i_x_start;
  logic [9:0]        i_x_end;
  logic [9:0]        i_y;
  logic              i_abort;
  logic              o_pack_start;
  logic [4:0]        o_pack_start_index;
  logic [4:0]        o_pack_end_index;
  logic [ADDR_W-1:0] o_burst_addr;
  logic              i_pack_done;
  logic              o_busy;
  logic              o_line_done;
  logic              o_cmd_err;

  modport slave (
    input  i_cmd_valid, i_x_start, i_x_end, i_y, i_abort, i_pack_done,
    output o_cmd_ready, o_pack_start, o_pack_start_index, o_pack_end_index,
           o_burst_addr, o_busy, o_line_done, o_cmd_err
  );

  modport master (
    output i_cmd_valid, i_x_start, i_x_end, i_y, i_abort, i_pack_done,
    input  o_cmd_ready, o_pack_start, o_pack_start_index, o_pack_end_index,
           o_burst_addr, o_busy, o_line_done, o_cmd_err
  );
endinterface

// File: rtl/packer_scheduler.sv
// Splits one row segment [x_start, x_end] into 32-pixel bursts and hands them
// to the packer one at a time, waiting for each packer done before the next.
module packer_scheduler #(
  parameter int H_RES  = 320,
  parameter int ADDR_W = 16
) (
  input  logic                i_clk,
  input  logic                i_rst,
  packer_scheduler_if.slave   bus
);
  localparam int BPL = H_RES / 32;

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT
  } state_t;

  state_t            state_reg, state_next;
  logic [4:0]        burst_reg, burst_next;
  logic [4:0]        last_reg, last_next;
  logic [4:0]        xe_lo_reg, xe_lo_next;
  logic [4:0]        start_idx_reg, start_idx_next;
  logic [4:0]        end_idx_reg, end_idx_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic              abort_reg, abort_next;
  logic              line_done_reg, line_done_next;
  logic              cmd_err_reg, cmd_err_next;

  logic              cmd_ready;
  logic              accept;
  logic              cmd_bad;
  logic              abort_seen;
  logic [4:0]        burst_inc;
  logic [ADDR_W-1:0] addr_cmd;

  assign cmd_ready  = (state_reg == IDLE) & ~i_rst;
  assign accept     = bus.i_cmd_valid & cmd_ready;
  assign cmd_bad    = (bus.i_x_start > bus.i_x_end) ||
                      (32'(bus.i_x_end) >= 32'(H_RES));
  // Row base in burst units plus the first burst column, wrapped to the address width.
  assign addr_cmd   = ADDR_W'(bus.i_y) * ADDR_W'(BPL) + ADDR_W'(bus.i_x_start[9:5]);
  assign burst_inc  = burst_reg + 5'd1;
  assign abort_seen = abort_reg | bus.i_abort;

  always_comb begin
    state_next     = state_reg;
    burst_next     = burst_reg;
    last_next      = last_reg;
    xe_lo_next     = xe_lo_reg;
    start_idx_next = start_idx_reg;
    end_idx_next   = end_idx_reg;
    addr_next      = addr_reg;
    abort_next     = abort_reg;
    line_done_next = 1'b0;
    cmd_err_next   = 1'b0;

    case (state_reg)
      IDLE: begin
        abort_next = 1'b0;
        if (accept) begin
          if (cmd_bad) begin
            cmd_err_next = 1'b1;
          end else begin
            burst_next     = bus.i_x_start[9:5];
            last_next      = bus.i_x_end[9:5];
            xe_lo_next     = bus.i_x_end[4:0];
            start_idx_next = bus.i_x_start[4:0];
            end_idx_next   = (bus.i_x_start[9:5] == bus.i_x_end[9:5]) ?
                             bus.i_x_end[4:0] : 5'd31;
            addr_next      = addr_cmd;
            state_next     = START;
          end
        end
      end

      START: begin
        abort_next = abort_seen;
        state_next = WAIT;
      end

      WAIT: begin
        abort_next = abort_seen;
        if (bus.i_pack_done) begin
          if (burst_reg == last_reg) begin
            line_done_next = 1'b1;
            abort_next     = 1'b0;
            state_next     = IDLE;
          end else if (abort_seen) begin
            // The burst just written was allowed to finish; nothing more is issued.
            abort_next = 1'b0;
            state_next = IDLE;
          end else begin
            burst_next     = burst_inc;
            addr_next      = addr_reg + ADDR_W'(1);
            start_idx_next = 5'd0;
            end_idx_next   = (burst_inc == last_reg) ? xe_lo_reg : 5'd31;
            state_next     = START;
          end
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg     <= IDLE;
      burst_reg     <= '0;
      last_reg      <= '0;
      xe_lo_reg     <= '0;
      start_idx_reg <= '0;
      end_idx_reg   <= '0;
      addr_reg      <= '0;
      abort_reg     <= 1'b0;
      line_done_reg <= 1'b0;
      cmd_err_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      burst_reg     <= burst_next;
      last_reg      <= last_next;
      xe_lo_reg     <= xe_lo_next;
      start_idx_reg <= start_idx_next;
      end_idx_reg   <= end_idx_next;
      addr_reg      <= addr_next;
      abort_reg     <= abort_next;
      line_done_reg <= line_done_next;
      cmd_err_reg   <= cmd_err_next;
    end
  end

  assign bus.o_cmd_ready        = cmd_ready;
  assign bus.o_pack_start       = (state_reg == START);
  assign bus.o_busy             = (state_reg != IDLE);
  assign bus.o_pack_start_index = start_idx_reg;
  assign bus.o_pack_end_index   = end_idx_reg;
  assign bus.o_burst_addr       = addr_reg;
  assign bus.o_line_done        = line_done_reg;
  assign bus.o_cmd_err          = cmd_err_reg;
endmodule

// File: tb/tb_packer_scheduler.sv
// Directed bench for packer_scheduler: a queue-based burst model checked every cycle,
// plus literal expectations for the documented scenarios.
module tb_packer_scheduler;
  localparam int H_RES  = 320;
  localparam int ADDR_W = 16;
  localparam int BPL    = H_RES / 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  packer_scheduler_if #(.ADDR_W(ADDR_W)) bus ();

  packer_scheduler #(.H_RES(H_RES), .ADDR_W(ADDR_W)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Behavioural model: a command expands into a queue of bursts up front.
  typedef struct {
    int si;
    int ei;
    int addr;
  } burst_t;

  burst_t mq[$];
  burst_t m_cur = '{0, 0, 0};
  bit m_busy = 0, m_start = 0, m_wait = 0, m_ld = 0, m_err = 0, m_abort = 0;
  bit model_live = 0;

  always @(posedge clk) begin
    bit was_start;
    int xs, xe, yy;
    cyc++;
    model_live = 1;
    if (rst) begin
      m_busy = 0; m_start = 0; m_wait = 0; m_ld = 0; m_err = 0; m_abort = 0;
      mq.delete();
      m_cur = '{0, 0, 0};
    end else begin
      was_start = m_start;
      m_start = 0; m_ld = 0; m_err = 0;
      if (!m_busy) begin
        if (bus.i_cmd_valid) begin
          xs = int'(bus.i_x_start); xe = int'(bus.i_x_end); yy = int'(bus.i_y);
          if (xs > xe || xe >= H_RES) begin
            m_err = 1;
          end else begin
            mq.delete();
            for (int b = xs / 32; b <= xe / 32; b++)
              mq.push_back('{(b == xs / 32) ? xs % 32 : 0,
                             (b == xe / 32) ? xe % 32 : 31,
                             (yy * BPL + b) % (1 << ADDR_W)});
            m_cur = mq.pop_front();
            m_busy = 1; m_start = 1; m_wait = 0; m_abort = 0;
          end
        end
      end else begin
        if (bus.i_abort) m_abort = 1;
        if (was_start) begin
          m_wait = 1;
        end else if (m_wait && bus.i_pack_done) begin
          m_wait = 0;
          if (mq.size() == 0) begin
            m_ld = 1; m_busy = 0; m_abort = 0;
          end else if (m_abort) begin
            m_busy = 0; m_abort = 0; mq.delete();
          end else begin
            m_cur = mq.pop_front();
            m_start = 1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (model_live) begin
      chk("cmd_ready",   bus.o_cmd_ready,        (!m_busy && !rst) ? 1 : 0);
      chk("pack_start",  bus.o_pack_start,       m_start);
      chk("busy",        bus.o_busy,             m_busy);
      chk("line_done",   bus.o_line_done,        m_ld);
      chk("cmd_err",     bus.o_cmd_err,          m_err);
      chk("start_index", bus.o_pack_start_index, m_cur.si);
      chk("end_index",   bus.o_pack_end_index,   m_cur.ei);
      chk("burst_addr",  bus.o_burst_addr,       m_cur.addr);
    end
  end

  // Event log of DUT activity, used by the literal scenario checks.
  typedef struct {
    int si;
    int ei;
    int addr;
    int cyc;
  } ev_t;

  ev_t slog[$];
  int  dlog[$];
  int  ldlog[$];
  int  n_err = 0;

  always @(negedge clk) begin
    if (bus.o_pack_start === 1'b1) begin
      slog.push_back('{int'(bus.o_pack_start_index), int'(bus.o_pack_end_index),
                       int'(bus.o_burst_addr), cyc});
      $display("start  cyc=%0d idx=%0d..%0d addr=%0d", cyc, bus.o_pack_start_index,
               bus.o_pack_end_index, bus.o_burst_addr);
    end
    if (bus.i_pack_done === 1'b1) dlog.push_back(cyc);
    if (bus.o_line_done === 1'b1) ldlog.push_back(cyc);
    if (bus.o_cmd_err === 1'b1) n_err++;
  end

  task automatic send_cmd(input int xs, input int xe, input int y);
    bit taken = 0;
    @(posedge clk); #2;
    bus.i_cmd_valid = 1'b1;
    bus.i_x_start   = 10'(xs);
    bus.i_x_end     = 10'(xe);
    bus.i_y         = 10'(y);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.o_cmd_ready === 1'b1) begin
        taken = 1;
        break;
      end
    end
    @(posedge clk); #2;
    bus.i_cmd_valid = 1'b0;
    bus.i_x_start   = 10'($urandom_range(0, 1023));
    bus.i_x_end     = 10'($urandom_range(0, 1023));
    bus.i_y         = 10'($urandom_range(0, 1023));
    $display("cmd    x=%0d..%0d y=%0d taken=%0d", xs, xe, y, taken);
    n_checks++;
    if (!taken) begin
      n_fail++;
      $display("FAIL cmd_accept: o_cmd_ready got 0 for 200 cycles, expected 1");
    end
  endtask

  task automatic wait_start();
    bit seen = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (bus.o_pack_start === 1'b1) begin
        seen = 1;
        break;
      end
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL wait_start: o_pack_start got 0 for 64 cycles, expected 1");
    end
  endtask

  task automatic pulse_done(input int d);
    repeat (d) @(posedge clk);
    #2 bus.i_pack_done = 1'b1;
    @(posedge clk);
    #2 bus.i_pack_done = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  int sb, db, lb, eb;

  initial begin
    bus.i_cmd_valid = 1'b0;
    bus.i_x_start   = '0;
    bus.i_x_end     = '0;
    bus.i_y         = '0;
    bus.i_abort     = 1'b0;
    bus.i_pack_done = 1'b0;
    idle(3);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_ready", bus.o_cmd_ready, 1);
    chk("reset_busy",  bus.o_busy,      0);

    // Three bursts on row 2
    sb = slog.size(); db = dlog.size(); lb = ldlog.size();
    send_cmd(5, 70, 2);
    pulse_done(2); wait_start();
    pulse_done(1); wait_start();
    pulse_done(3);
    idle(3);
    chk("t1_nstarts", slog.size() - sb, 3);
    chk("t1_s0_si",   slog[sb].si, 5);
    chk("t1_s0_ei",   slog[sb].ei, 31);
    chk("t1_s0_addr", slog[sb].addr, 20);
    chk("t1_s1_si",   slog[sb+1].si, 0);
    chk("t1_s1_ei",   slog[sb+1].ei, 31);
    chk("t1_s1_addr", slog[sb+1].addr, 21);
    chk("t1_s2_si",   slog[sb+2].si, 0);
    chk("t1_s2_ei",   slog[sb+2].ei, 6);
    chk("t1_s2_addr", slog[sb+2].addr, 22);
    chk("t1_lat1",    slog[sb+1].cyc, dlog[db] + 1);
    chk("t1_lat2",    slog[sb+2].cyc, dlog[db+1] + 1);
    chk("t1_ld_lat",  ldlog[lb], dlog[db+2] + 1);
    chk("t1_nld",     ldlog.size() - lb, 1);

    // Single-burst segment
    sb = slog.size(); lb = ldlog.size();
    send_cmd(40, 40, 7);
    pulse_done(1);
    idle(2);
    chk("t2_nstarts", slog.size() - sb, 1);
    chk("t2_si",      slog[sb].si, 8);
    chk("t2_ei",      slog[sb].ei, 8);
    chk("t2_addr",    slog[sb].addr, 71);
    chk("t2_nld",     ldlog.size() - lb, 1);
    chk("t2_busy",    bus.o_busy, 0);

    // Rejected commands
    sb = slog.size(); eb = n_err;
    send_cmd(100, 50, 0);
    send_cmd(0, 320, 0);
    idle(3);
    chk("t3_nerr",    n_err - eb, 2);
    chk("t3_nstarts", slog.size() - sb, 0);

    // Abort during the first WAIT
    sb = slog.size(); lb = ldlog.size();
    send_cmd(0, 95, 0);
    @(posedge clk); #2 bus.i_abort = 1'b1;
    @(posedge clk); #2 bus.i_abort = 1'b0;
    pulse_done(1);
    idle(10);
    chk("t4_nstarts", slog.size() - sb, 1);
    chk("t4_nld",     ldlog.size() - lb, 0);
    chk("t4_busy",    bus.o_busy, 0);

    // Reset in WAIT of burst 1 of 3, stray done, then a fresh command
    sb = slog.size(); lb = ldlog.size();
    send_cmd(0, 95, 3);
    pulse_done(1); wait_start();
    @(posedge clk); #2 rst = 1'b1;
    @(posedge clk); #2 rst = 1'b0;
    @(negedge clk);
    chk("t5_rst_busy",  bus.o_busy, 0);
    chk("t5_rst_start", bus.o_pack_start, 0);
    chk("t5_rst_addr",  bus.o_burst_addr, 0);
    chk("t5_rst_ei",    bus.o_pack_end_index, 0);
    pulse_done(1);
    idle(5);
    chk("t5_nstarts", slog.size() - sb, 2);
    send_cmd(0, 31, 1);
    pulse_done(1);
    idle(3);
    chk("t5_nstarts2", slog.size() - sb, 3);
    chk("t5_si",       slog[sb+2].si, 0);
    chk("t5_ei",       slog[sb+2].ei, 31);
    chk("t5_addr",     slog[sb+2].addr, 10);
    chk("t5_nld",      ldlog.size() - lb, 1);

    // Back-to-back: second command held valid while the first runs
    sb = slog.size(); lb = ldlog.size();
    fork
      begin
        send_cmd(20, 63, 4);
        send_cmd(0, 5, 5);
      end
      begin
        wait_start(); pulse_done(2);
        wait_start(); pulse_done(1);
        wait_start(); pulse_done(1);
      end
    join
    idle(3);
    chk("t6_nstarts", slog.size() - sb, 3);
    chk("t6_s0_addr", slog[sb].addr, 40);
    chk("t6_s0_si",   slog[sb].si, 20);
    chk("t6_s1_addr", slog[sb+1].addr, 41);
    chk("t6_s2_addr", slog[sb+2].addr, 50);
    chk("t6_s2_ei",   slog[sb+2].ei, 5);
    chk("t6_b2b_lat", slog[sb+2].cyc, ldlog[lb] + 1);
    chk("t6_nld",     ldlog.size() - lb, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/packer_scheduler.md
Name: packer_scheduler

Overview:
- Sequences the 32-pixel burst packer for one row segment per command: splits [x_start, x_end] on row y into 32-pixel bursts.
- For each burst it issues one packer start with the in-burst start/end indices and the PSRAM burst address, then waits for the packer's done before issuing the next.
- Sits between the SPI pixel-window decoder (command source) and the packer/PSRAM write path.

Parameters:
H_RES, 320, active pixels per row; must be a multiple of 32.
ADDR_W, 16, width of PSRAM burst address (burst units of 32 pixels = 64 bytes).

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous reset, active-high
i_cmd_valid  in  1  segment command valid
o_cmd_ready  out  1  command accepted when valid&ready
i_x_start  in  10  first pixel column (inclusive)
i_x_end  in  10  last pixel column (inclusive)
i_y  in  10  row
i_abort  in  1  stop after current burst
o_pack_start  out  1  one-cycle start pulse to packer
o_pack_start_index  out  5  first valid pixel slot in burst
o_pack_end_index  out  5  last valid pixel slot in burst
o_burst_addr  out  ADDR_W  PSRAM burst address of current burst
i_pack_done  in  1  packer finished PSRAM write (1-cycle pulse)
o_busy  out  1  segment in progress
o_line_done  out  1  one-cycle pulse: all bursts of segment written
o_cmd_err  out  1  one-cycle pulse: command rejected

Behaviour:
- Reset (i_rst high at clock edge): state IDLE; o_pack_start, o_line_done, o_cmd_err, o_busy = 0; indices, o_burst_addr, burst counter = 0; latched abort cleared. o_cmd_ready = (state==IDLE) & ~i_rst. Reset mid-segment drops the segment with no further start pulse; the packer's pending done is ignored.
- BPL = H_RES/32. Burst b spans columns 32b..32b+31. first = x_start[9:5], last = x_end[9:5].
- Validation on accept: error if x_start > x_end or x_end >= H_RES.
  - On error: o_cmd_err pulses in cycle N+1, state stays IDLE, no o_pack_start.
- States: IDLE, START, WAIT.
  - IDLE: on valid&ready at edge N with a valid command, register b=first, last, start index, end index, and o_burst_addr = y*BPL + first (truncated to ADDR_W); go to START. o_busy=1 from N+1.
  - START (exactly one cycle): o_pack_start=1.
    - o_pack_start_index = x_start[4:0] if b==first, else 0.
    - o_pack_end_index = x_end[4:0] if b==last, else 31.
    - Indices and o_burst_addr are stable from the START cycle until the next START or IDLE. Next state: WAIT.
  - WAIT: on i_pack_done:
    - If b==last: pulse o_line_done next cycle and go to IDLE.
    - Else if abort is latched: go to IDLE with no o_line_done.
    - Otherwise: b+1, o_burst_addr+1, recompute indices, go to START. The next o_pack_start is the cycle after the done (done at M -> start at M+1).
- i_abort: sampled in any non-IDLE state and latched. It never cuts a burst short, because the packer cannot be stopped. The latch clears on entering IDLE. i_abort in IDLE has no effect.
- Command to packer start latency: 1 cycle (accept at N, o_pack_start high in N+1).
- i_pack_done outside WAIT is ignored.
- Command fields are sampled only at accept; later changes have no effect.
- The multiply y*BPL may be registered over one extra cycle only if START still begins at N+1. Otherwise it is a single-cycle combinational multiply.
- Single-burst segment (first==last): both indices come from the command, and o_line_done follows the first done.

Test Plan:
- H_RES=320, cmd x 5..70, y=2:
  - three starts: (idx 5..31, addr 20), (0..31, addr 21), (0..6, addr 22).
  - each start is 1 cycle after the preceding done.
  - o_line_done 1 cycle after the 3rd done.
- Cmd x 40..40, y=7 -> one start, idx 8..8, addr 71; o_line_done after done; o_busy low afterwards.
- Cmd x 100..50, then cmd x 0..320 -> o_cmd_err pulse each time, no o_pack_start, o_cmd_ready back to 1 next cycle.
- Cmd x 0..95, y=0, i_abort pulsed during the 1st WAIT -> burst 0 completes, no second start, no o_line_done, IDLE after done.
- i_rst asserted in WAIT of burst 1 of 3:
  - all outputs 0 the next cycle.
  - a later stray i_pack_done causes nothing.
  - a new cmd x 0..31, y=1 gives start idx 0..31, addr 10.
- Back-to-back: valid held with a second cmd queued -> second accepted only in IDLE after o_line_done of the first, start 1 cycle later.
